spi_controller: RTL and testbench

Synchronous SPI initiator for the chip's write-only register-file protocol. It accepts one write request per valid/ready handshake and serialises it as a 16-bit mode-0 frame on nCS/SCLK/COPI. The frame is one R/W bit, a 7-bit address and 8 data bits. The block sits in test/bring-up logic and in any on-chip master that must program the SPI register peripheral over the same pins.

---
 rtl/spi_controller_if.sv | 24 ++
 rtl/spi_controller.sv | 137 +++++++++++++
 tb/tb_spi_controller.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/spi_controller_if.sv
// Request handshake, status and SPI pin bundle for spi_controller.
// The controller takes the slave modport; the requester takes the master modport.
interface spi_controller_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_rw;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       busy;
  logic       done;
  logic       SCLK;
  logic       COPI;
  logic       nCS;

  modport master (
    output req_valid, req_rw, req_addr, req_data,
    input  req_ready, busy, done, SCLK, COPI, nCS
  );

  modport slave (
    input  req_valid, req_rw, req_addr, req_data,
    output req_ready, busy, done, SCLK, COPI, nCS
  );
endinterface

// File: rtl/spi_controller.sv
// Write-only SPI mode-0 initiator: one 16-bit frame {rw, addr, data} per accepted request.
// IDLE: ready | SETUP: nCS low before first SCLK | SHIFT: 16 bits | HOLD: nCS low after last SCLK | GAP: nCS high minimum
module spi_controller #(
  parameter int CLK_DIV   = 4,
  parameter int LSB_FIRST = 1,
  parameter int CS_SETUP  = 2,
  parameter int CS_HOLD   = 2,
  parameter int CS_IDLE   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  spi_controller_if.slave   bus
);

  localparam int MAXP_A = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int MAXP_B = (CS_HOLD > CS_IDLE) ? CS_HOLD : CS_IDLE;
  localparam int MAXP   = (MAXP_A > MAXP_B) ? MAXP_A : MAXP_B;
  localparam int CW     = (MAXP > 1) ? $clog2(MAXP) : 1;

  localparam logic [CW-1:0] HALF_LD  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] SETUP_LD = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(CS_HOLD - 1);
  localparam logic [CW-1:0] IDLE_LD  = CW'(CS_IDLE - 1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bit;
  logic [15:0]   r_shift;
  logic          r_sclk;
  logic          r_copi;
  logic          r_ncs;
  logic          r_done;
  logic          r_busy;
  logic          r_ready;
  logic [15:0]   w_frame;

  // Frame bit i is the i-th bit on the wire.
  always_comb begin
    w_frame    = '0;
    w_frame[0] = bus.req_rw;
    for (int i = 0; i < 7; i++)
      w_frame[1+i] = (LSB_FIRST != 0) ? bus.req_addr[i] : bus.req_addr[6-i];
    for (int i = 0; i < 8; i++)
      w_frame[8+i] = (LSB_FIRST != 0) ? bus.req_data[i] : bus.req_data[7-i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_sclk  <= 1'b0;
      r_copi  <= 1'b0;
      r_ncs   <= 1'b1;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_ready <= 1'b1;
          if (bus.req_valid && r_ready) begin
            r_state <= SETUP;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            r_ncs   <= 1'b0;
            r_shift <= w_frame;
            r_copi  <= w_frame[0];
            r_cnt   <= SETUP_LD;
          end
        end
        SETUP: begin
          if (r_cnt == '0) begin
            r_state <= SHIFT;
            r_cnt   <= HALF_LD;
            r_bit   <= '0;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        SHIFT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else if (!r_sclk) begin
            r_sclk <= 1'b1;
            r_cnt  <= HALF_LD;
          end else begin
            // Falling edge: the next bit goes out in the same cycle SCLK drops.
            r_sclk <= 1'b0;
            if (r_bit == 4'd15) begin
              r_state <= HOLD;
              r_copi  <= 1'b0;
              r_cnt   <= HOLD_LD;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_shift <= {1'b0, r_shift[15:1]};
              r_copi  <= r_shift[1];
              r_cnt   <= HALF_LD;
            end
          end
        end
        HOLD: begin
          if (r_cnt == '0) begin
            r_state <= GAP;
            r_ncs   <= 1'b1;
            r_done  <= 1'b1;
            r_cnt   <= IDLE_LD;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        GAP: begin
          if (r_cnt == '0) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.req_ready = r_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.SCLK      = r_sclk;
  assign bus.COPI      = r_copi;
  assign bus.nCS       = r_ncs;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: defaults, MSB-first and minimum-timing instances.
module tb_spi_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_rw = 1'b0;
  logic [6:0] req_addr = '0;
  logic [7:0] req_data = '0;
  int         sel = 0;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  spi_controller_if if0 ();
  spi_controller_if if1 ();
  spi_controller_if if2 ();

  assign if0.req_valid = req_valid && (sel == 0);
  assign if1.req_valid = req_valid && (sel == 1);
  assign if2.req_valid = req_valid && (sel == 2);
  assign if0.req_rw = req_rw;  assign if0.req_addr = req_addr;  assign if0.req_data = req_data;
  assign if1.req_rw = req_rw;  assign if1.req_addr = req_addr;  assign if1.req_data = req_data;
  assign if2.req_rw = req_rw;  assign if2.req_addr = req_addr;  assign if2.req_data = req_data;

  spi_controller u0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  spi_controller #(.LSB_FIRST(0)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  spi_controller #(.CLK_DIV(1), .CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(1)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2));

  logic m_sclk, m_copi, m_ncs, m_done, m_ready, m_busy;
  always_comb begin
    case (sel)
      0: begin
        m_sclk = if0.SCLK; m_copi = if0.COPI; m_ncs = if0.nCS;
        m_done = if0.done; m_ready = if0.req_ready; m_busy = if0.busy;
      end
      1: begin
        m_sclk = if1.SCLK; m_copi = if1.COPI; m_ncs = if1.nCS;
        m_done = if1.done; m_ready = if1.req_ready; m_busy = if1.busy;
      end
      default: begin
        m_sclk = if2.SCLK; m_copi = if2.COPI; m_ncs = if2.nCS;
        m_done = if2.done; m_ready = if2.req_ready; m_busy = if2.busy;
      end
    endcase
  end

  typedef struct {
    logic [15:0] bits;
    int nrise, low, ndone, done_at, gap, viol, first_rise, last_rise, ncyc;
    bit tmo;
  } cap_t;

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (m_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
  endtask

  task automatic send(input logic rw, input logic [6:0] a, input logic [7:0] d);
    bit ok;
    wait_ready(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ready_wait: req_ready=0 after 400 cycles, expected 1"); end
    req_rw = rw; req_addr = a; req_data = d; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // Starts on the negedge after the accepting edge; returns on the negedge where req_ready is back.
  task automatic capture(output cap_t c);
    logic ps, pc;
    c = '{default: 0};
    c.tmo = 1'b1;
    c.first_rise = -1;
    ps = 1'b0;
    pc = m_copi;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (m_ready) begin c.ncyc = cyc; c.tmo = 1'b0; break; end
      if (!m_ncs) c.low++;
      if (m_sclk && !ps) begin
        if (c.nrise < 16) c.bits[c.nrise] = m_copi;
        if (c.nrise == 0) c.first_rise = cyc;
        c.last_rise = cyc;
        c.nrise++;
      end
      if (m_sclk && (m_copi !== pc)) c.viol++;
      if (c.nrise == 16 && !m_sclk && m_copi) c.viol++;
      if (m_ncs && m_sclk) c.viol++;
      if (m_done) begin c.ndone++; c.done_at = cyc; end
      if (m_ncs && c.low > 0) c.gap++;
      ps = m_sclk;
      pc = m_copi;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    sel = 0;
    rst_n = 1'b0;
    req_valid = 1'b1;
    req_rw = 1'b1; req_addr = 7'h12; req_data = 8'h34;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({m_sclk, m_ncs, m_copi, m_done, m_busy, m_ready} !== 6'b010000) begin
        failures++;
        $display("FAIL reset_outputs cycle %0d: sclk,ncs,copi,done,busy,ready=%b expected 010000",
                 i, {m_sclk, m_ncs, m_copi, m_done, m_busy, m_ready});
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({m_ready, m_ncs, m_busy} !== 3'b110) begin
      failures++;
      $display("FAIL reset_release: ready,ncs,busy=%b expected 110", {m_ready, m_ncs, m_busy});
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_write();
    cap_t c;
    sel = 0;
    send(1'b1, 7'h02, 8'hA5);
    capture(c);
    checks++; if (c.tmo) begin failures++; $display("FAIL single_timeout: frame did not finish"); end
    checks++; if (c.bits !== 16'hA505) begin failures++; $display("FAIL single_bits: got %h expected a505", c.bits); end
    checks++; if (c.nrise != 16) begin failures++; $display("FAIL single_rises: got %0d expected 16", c.nrise); end
    checks++; if (c.low != 132) begin failures++; $display("FAIL single_ncs_low: got %0d expected 132", c.low); end
    checks++; if (c.ndone != 1 || c.done_at != 132) begin
      failures++; $display("FAIL single_done: count %0d at %0d expected 1 at 132", c.ndone, c.done_at); end
    checks++; if (c.viol != 0) begin failures++; $display("FAIL single_mode0: violations %0d expected 0", c.viol); end
    checks++; if (c.first_rise != 6 || c.last_rise != 126) begin
      failures++; $display("FAIL single_sclk_timing: first %0d last %0d expected 6 126", c.first_rise, c.last_rise); end
    checks++; if (c.gap != 4) begin failures++; $display("FAIL single_gap: got %0d expected 4", c.gap); end
  endtask

  task automatic test_msb_first();
    cap_t c;
    sel = 1;
    send(1'b1, 7'h04, 8'h3C);
    capture(c);
    checks++; if (c.bits !== 16'h3C21) begin failures++; $display("FAIL msb_bits: got %h expected 3c21", c.bits); end
    checks++; if (c.nrise != 16 || c.low != 132) begin
      failures++; $display("FAIL msb_frame: rises %0d low %0d expected 16 132", c.nrise, c.low); end
    checks++; if (c.viol != 0) begin failures++; $display("FAIL msb_mode0: violations %0d expected 0", c.viol); end
  endtask

  task automatic test_back_to_back();
    cap_t c1, c2;
    bit ok;
    sel = 0;
    wait_ready(ok);
    checks++; if (!ok) begin failures++; $display("FAIL b2b_ready_wait: req_ready=0, expected 1"); end
    req_rw = 1'b1; req_addr = 7'h01; req_data = 8'h11; req_valid = 1'b1;
    @(negedge clk);
    req_addr = 7'h03; req_data = 8'h33;
    capture(c1);
    @(negedge clk);
    checks++; if (m_ncs !== 1'b0) begin failures++; $display("FAIL b2b_second_accept: ncs=%b expected 0", m_ncs); end
    req_valid = 1'b0;
    req_rw = 1'b0; req_addr = 7'h7F; req_data = 8'hFF;
    capture(c2);
    checks++; if (c1.bits !== 16'h1103) begin failures++; $display("FAIL b2b_frame1_bits: got %h expected 1103", c1.bits); end
    checks++; if (c1.gap != 4 || c1.ncyc != 136) begin
      failures++; $display("FAIL b2b_spacing: gap %0d ready at %0d expected 4 136", c1.gap, c1.ncyc); end
    checks++; if (c2.bits !== 16'h3307) begin failures++; $display("FAIL b2b_frame2_bits: got %h expected 3307", c2.bits); end
    checks++; if (c2.ndone != 1 || c2.low != 132) begin
      failures++; $display("FAIL b2b_frame2: done %0d low %0d expected 1 132", c2.ndone, c2.low); end
  endtask

  task automatic test_reset_mid_frame();
    cap_t c;
    int rises, dones;
    logic ps;
    sel = 0;
    send(1'b1, 7'h55, 8'hC3);
    rises = 0; dones = 0; ps = m_sclk;
    for (int i = 0; i < 200 && rises < 5; i++) begin
      if (m_sclk && !ps) rises++;
      if (m_done) dones++;
      ps = m_sclk;
      if (rises < 5) @(negedge clk);
    end
    checks++; if (rises != 5) begin failures++; $display("FAIL midrst_rises: got %0d expected 5", rises); end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({m_sclk, m_ncs, m_copi, m_done, m_busy} !== 5'b01000) begin
      failures++;
      $display("FAIL midrst_outputs: sclk,ncs,copi,done,busy=%b expected 01000", {m_sclk, m_ncs, m_copi, m_done, m_busy});
    end
    @(negedge clk);
    if (m_done) dones++;
    rst_n = 1'b1;
    @(negedge clk);
    if (m_done) dones++;
    checks++; if (dones != 0) begin failures++; $display("FAIL midrst_no_done: got %0d pulses expected 0", dones); end
    send(1'b1, 7'h55, 8'hC3);
    capture(c);
    checks++; if (c.bits !== 16'hC3AB) begin failures++; $display("FAIL midrst_refresh_bits: got %h expected c3ab", c.bits); end
    checks++; if (c.ndone != 1 || c.low != 132) begin
      failures++; $display("FAIL midrst_refresh_frame: done %0d low %0d expected 1 132", c.ndone, c.low); end
  endtask

  task automatic test_fast_config();
    cap_t c;
    sel = 2;
    send(1'b0, 7'h7F, 8'h80);
    capture(c);
    checks++; if (c.bits !== 16'h80FE) begin failures++; $display("FAIL fast_bits: got %h expected 80fe", c.bits); end
    checks++; if (c.nrise != 16 || c.low != 34) begin
      failures++; $display("FAIL fast_frame: rises %0d low %0d expected 16 34", c.nrise, c.low); end
    checks++; if (c.ndone != 1 || c.done_at != 34) begin
      failures++; $display("FAIL fast_done: count %0d at %0d expected 1 34", c.ndone, c.done_at); end
    checks++; if (c.first_rise != 2 || (c.last_rise - c.first_rise) != 30) begin
      failures++; $display("FAIL fast_sclk_period: first %0d span %0d expected 2 30", c.first_rise, c.last_rise - c.first_rise); end
    checks++; if (c.gap != 1 || c.viol != 0) begin
      failures++; $display("FAIL fast_gap_mode0: gap %0d viol %0d expected 1 0", c.gap, c.viol); end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_msb_first();
    test_back_to_back();
    test_reset_mid_frame();
    test_fast_config();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
